// File: rtl/matmul_rr_scheduler.sv
// ---------------------------------------------------------------------------
// matmul_rr_scheduler
//
// Shares a single 2x2 8-bit matrix multiplier (start/done handshake) between
// NUM_REQ client engines. A round-robin arbiter picks one pending client in
// IDLE and latches its operands. The block then pulses mm_start_o, waits for
// mm_done_i (or aborts on timeout) and returns the 4x16-bit result to the
// granted client with a one-cycle, one-hot rsp_valid_o pulse.
//
// Ports
//   clk_i        in   1            clock, rising edge
//   rst_i        in   1            asynchronous, active-high reset
//   req_i        in   NUM_REQ      per-client request level
//   req_a_i      in   NUM_REQ*32   client i operand A at [32i+:32], {a22,a21,a12,a11}
//   req_b_i      in   NUM_REQ*32   client i operand B, same packing
//   rsp_valid_o  out  NUM_REQ      one-cycle, one-hot completion pulse
//   rsp_c_o      out  64           result {c22,c21,c12,c11}, held until the next response
//   rsp_err_o    out  1            1 = transaction timed out (rsp_c_o is 0)
//   busy_o       out  1            high whenever the scheduler is not IDLE
//   gnt_id_o     out  IDW          current or last granted client
//   mm_start_o   out  1            multiplier start pulse
//   mm_a_o       out  32           latched operand A to the multiplier
//   mm_b_o       out  32           latched operand B to the multiplier
//   mm_c_i       in   64           multiplier result
//   mm_done_i    in   1            multiplier done pulse
// ---------------------------------------------------------------------------
module matmul_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ*32-1:0]  req_a_i,
    input  logic [NUM_REQ*32-1:0]  req_b_i,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    output logic [63:0]            rsp_c_o,
    output logic                   rsp_err_o,
    output logic                   busy_o,
    output logic [IDW-1:0]         gnt_id_o,
    output logic                   mm_start_o,
    output logic [31:0]            mm_a_o,
    output logic [31:0]            mm_b_o,
    input  logic [63:0]            mm_c_i,
    input  logic                   mm_done_i
);

    localparam int CNTW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       gnt_q, gnt_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [31:0]          a_q, a_d;
    logic [31:0]          b_q, b_d;
    logic [63:0]          c_q, c_d;
    logic                 err_q, err_d;
    logic [NUM_REQ-1:0]   vld_q, vld_d;

    logic [IDW-1:0]       sel;
    logic                 found;

    // (base + off) mod NUM_REQ, valid for base < NUM_REQ and off < NUM_REQ
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDW'(s);
    endfunction

    // Round-robin search: first set request at or above ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_i[wrap_idx(ptr_q, k)]) begin
                found = 1'b1;
                sel   = wrap_idx(ptr_q, k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        err_d   = err_q;
        vld_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    a_d     = req_a_i[{sel, 5'd0} +: 32];
                    b_d     = req_b_i[{sel, 5'd0} +: 32];
                    gnt_d   = sel;
                    ptr_d   = wrap_idx(sel, 1);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mm_done_i) begin
                    c_d          = mm_c_i;
                    err_d        = 1'b0;
                    vld_d[gnt_q] = 1'b1;
                    state_d      = S_RESP;
                end else if (cnt_q == CNTW'(TIMEOUT)) begin
                    // Counter has passed TIMEOUT-1 with no done: abort. On abort
                    // the response lands TIMEOUT+2 cycles after mm_start.
                    c_d          = '0;
                    err_d        = 1'b1;
                    vld_d[gnt_q] = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
        end
    end

    assign rsp_valid_o = vld_q;
    assign rsp_c_o     = c_q;
    assign rsp_err_o   = err_q;
    assign busy_o      = (state_q != S_IDLE);
    assign gnt_id_o    = gnt_q;
    assign mm_start_o  = (state_q == S_ISSUE);
    assign mm_a_o      = a_q;
    assign mm_b_o      = b_q;

endmodule
